// File: rtl/cnn_pkg.sv
// Shared CNN datapath definitions: default widths, pixel type and signed maximum helper.
// Used by maxpool_stream (optional feature macro: MAXPOOL_RELU_EN).
package cnn_pkg;

    localparam int DEFAULT_DATA_WIDTH = 16;
    localparam int DEFAULT_POOL       = 2;
    localparam int MAX_DATA_WIDTH     = 64;

    typedef logic signed [DEFAULT_DATA_WIDTH-1:0] pixel_t;
    typedef logic signed [MAX_DATA_WIDTH-1:0]     wide_t;

    // Operands arrive sign-extended to the widest supported pixel; a tie keeps 'stored'.
    function automatic wide_t signedMax(input wide_t stored, input wide_t incoming);
        return (incoming > stored) ? incoming : stored;
    endfunction

endpackage

// File: rtl/pool_line_buf.sv
// Partial-max line store for maxpool_stream: one combinational read and one write
// at the same address per cycle; contents are not reset.
module pool_line_buf #(
    parameter int DEPTH  = 12,
    parameter int WIDTH  = 16,
    localparam int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [WIDTH-1:0]  i_wdata,
    output logic [WIDTH-1:0]  o_rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_addr];

endmodule

// File: rtl/maxpool_stream.sv
// Streaming non-overlapping POOLxPOOL signed max-pooling over a row-major feature map.
// Define MAXPOOL_RELU_EN to clamp negative pooled results to zero at the output.
module maxpool_stream
    import cnn_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int POOL       = DEFAULT_POOL,
    parameter int MAP_W      = 24,
    parameter int MAP_H      = 24
) (
    input  logic                  clk,
    input  logic                  master_rst_n,
    input  logic                  frame_clr,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_last
);

    localparam int SLOTS  = MAP_W / POOL;
    localparam int COL_W  = (MAP_W > 1) ? $clog2(MAP_W) : 1;
    localparam int ROW_W  = (MAP_H > 1) ? $clog2(MAP_H) : 1;
    localparam int PH_W   = $clog2(POOL);
    localparam int SLOT_W = (SLOTS > 1) ? $clog2(SLOTS) : 1;

    if ((MAP_W % POOL) != 0 || (MAP_H % POOL) != 0 || POOL < 2 ||
        DATA_WIDTH > MAX_DATA_WIDTH) begin : g_badConfig
        $error("maxpool_stream: MAP_W and MAP_H must be multiples of POOL, POOL >= 2");
    end

    logic [COL_W-1:0]      r_col;
    logic [ROW_W-1:0]      r_row;
    logic [PH_W-1:0]       r_colPhase;
    logic [PH_W-1:0]       r_rowPhase;
    logic [SLOT_W-1:0]     r_slot;
    logic [DATA_WIDTH-1:0] r_outData;
    logic                  r_outValid;
    logic                  r_outLast;

    logic                  w_accept;
    logic                  w_colEnd;
    logic                  w_rowEnd;
    logic                  w_firstInWindow;
    logic                  w_windowDone;
    logic                  w_frameDone;
    logic [DATA_WIDTH-1:0] w_slotData;
    logic [DATA_WIDTH-1:0] w_max;
    logic [DATA_WIDTH-1:0] w_bufWrite;
    logic [DATA_WIDTH-1:0] w_result;

    assign in_ready        = (!r_outValid || out_ready) && !frame_clr;
    assign w_accept        = in_valid && in_ready;
    assign w_colEnd        = (r_col == COL_W'(MAP_W - 1));
    assign w_rowEnd        = (r_row == ROW_W'(MAP_H - 1));
    assign w_firstInWindow = (r_colPhase == '0) && (r_rowPhase == '0);
    assign w_windowDone    = (r_colPhase == PH_W'(POOL - 1)) && (r_rowPhase == PH_W'(POOL - 1));
    assign w_frameDone     = w_colEnd && w_rowEnd;

    assign w_max = DATA_WIDTH'(signedMax(MAX_DATA_WIDTH'(signed'(w_slotData)),
                                         MAX_DATA_WIDTH'(signed'(in_data))));
    assign w_bufWrite = w_firstInWindow ? in_data : w_max;

`ifdef MAXPOOL_RELU_EN
    assign w_result = w_max[DATA_WIDTH-1] ? '0 : w_max;
`else
    assign w_result = w_max;
`endif

    pool_line_buf #(
        .DEPTH (SLOTS),
        .WIDTH (DATA_WIDTH)
    ) u_lineBuf (
        .clk     (clk),
        .i_we    (w_accept),
        .i_addr  (r_slot),
        .i_wdata (w_bufWrite),
        .o_rdata (w_slotData)
    );

    // Phase counters track position inside the window so no divide/modulo is needed.
    always_ff @(posedge clk or negedge master_rst_n) begin
        if (!master_rst_n) begin
            r_col      <= '0;
            r_row      <= '0;
            r_colPhase <= '0;
            r_rowPhase <= '0;
            r_slot     <= '0;
        end else if (frame_clr) begin
            r_col      <= '0;
            r_row      <= '0;
            r_colPhase <= '0;
            r_rowPhase <= '0;
            r_slot     <= '0;
        end else if (w_accept) begin
            if (w_colEnd) begin
                r_col      <= '0;
                r_colPhase <= '0;
                r_slot     <= '0;
                if (w_rowEnd) begin
                    r_row      <= '0;
                    r_rowPhase <= '0;
                end else begin
                    r_row      <= r_row + 1'b1;
                    r_rowPhase <= (r_rowPhase == PH_W'(POOL - 1)) ? '0 : r_rowPhase + 1'b1;
                end
            end else begin
                r_col <= r_col + 1'b1;
                if (r_colPhase == PH_W'(POOL - 1)) begin
                    r_colPhase <= '0;
                    r_slot     <= r_slot + 1'b1;
                end else begin
                    r_colPhase <= r_colPhase + 1'b1;
                end
            end
        end
    end

    // A window completing on the same edge as an output transfer keeps out_valid high.
    always_ff @(posedge clk or negedge master_rst_n) begin
        if (!master_rst_n) begin
            r_outValid <= 1'b0;
            r_outLast  <= 1'b0;
            r_outData  <= '0;
        end else if (frame_clr) begin
            r_outValid <= 1'b0;
            r_outLast  <= 1'b0;
        end else if (w_accept && w_windowDone) begin
            r_outValid <= 1'b1;
            r_outLast  <= w_frameDone;
            r_outData  <= w_result;
        end else if (r_outValid && out_ready) begin
            r_outValid <= 1'b0;
            r_outLast  <= 1'b0;
        end
    end

    assign out_data  = r_outData;
    assign out_valid = r_outValid;
    assign out_last  = r_outLast;

endmodule

// File: tb/tb_maxpool_stream.sv
// Self-checking bench for maxpool_stream at MAP_W=MAP_H=4, POOL=2, DATA_WIDTH=16;
// expected negative results follow MAXPOOL_RELU_EN when it is defined.
module tb_maxpool_stream;

   localparam int DW = 16;

   typedef struct {
      logic [DW-1:0] data;
      logic          last;
   } exp_t;

   typedef struct {
      logic [DW-1:0] pix [16];
      logic [DW-1:0] res [4];
   } vec_t;

   logic          clk = 1'b0;
   logic          master_rst_n = 1'b0;
   logic          frame_clr = 1'b0;
   logic [DW-1:0] in_data = '0;
   logic          in_valid = 1'b0;
   logic          out_ready = 1'b1;
   logic          in_ready;
   logic [DW-1:0] out_data;
   logic          out_valid;
   logic          out_last;

   int   compared = 0;
   int   mismatched = 0;
   exp_t sbQ[$];
   vec_t vecs[4];
   vec_t partial;

   maxpool_stream #(
      .DATA_WIDTH (DW),
      .POOL       (2),
      .MAP_W      (4),
      .MAP_H      (4)
   ) dut (
      .clk          (clk),
      .master_rst_n (master_rst_n),
      .frame_clr    (frame_clr),
      .in_data      (in_data),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .out_data     (out_data),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .out_last     (out_last)
   );

   always #5 clk = ~clk;

   // One comparison: counts it, and reports a FAIL line when actual differs from expected.
   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      compared++;
      if (actual !== expected) begin
         mismatched++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   // Drives the first n pixels of a frame; when track is set, each completing window pushes its expected result.
   task automatic applyStimulus(input vec_t v, input int n, input bit track, output int cycles);
      int idx = 0;
      int win = 0;
      bit acc;
      exp_t e;
      cycles = 0;
      @(posedge clk);
      #1;
      in_valid = 1'b1;
      while (idx < n && cycles < 200) begin
         in_data = v.pix[idx];
         @(negedge clk);
         acc = in_ready;
         if (acc && track && (idx % 2) == 1 && ((idx / 4) % 2) == 1) begin
            e.data = v.res[win];
            e.last = (idx == 15);
            sbQ.push_back(e);
            win++;
         end
         @(posedge clk);
         #1;
         cycles++;
         if (acc) idx++;
      end
      in_valid = 1'b0;
      if (idx < n) checkOutput("stimulusTimeout", idx, n);
   endtask

   task automatic drainCheck(input string name);
      repeat (6) @(posedge clk);
      #1;
      checkOutput(name, sbQ.size(), 0);
   endtask

   // Scoreboard: a transfer is committed at the next rising edge, so it is judged at the falling edge before it.
   always @(negedge clk) begin : monitor
      exp_t e;
      if (master_rst_n && out_valid && out_ready) begin
         if (sbQ.size() == 0) begin
            checkOutput("unexpectedOutput", out_data, 32'hDEAD);
         end else begin
            e = sbQ.pop_front();
            checkOutput("outData", out_data, e.data);
            checkOutput("outLast", out_last, e.last);
         end
      end
   end

   initial begin : watchdog
      #100000;
      $display("[TB] FAIL watchdog: simulation did not complete, got timeout, expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin : main
      int cyc;
      int w;

      for (int i = 0; i < 16; i++) begin
         vecs[0].pix[i] = DW'(i);
         vecs[1].pix[i] = 16'hFFFF;
         vecs[3].pix[i] = DW'(15 - i);
         partial.pix[i] = DW'(100 + i);
      end
      vecs[0].res = '{16'd5, 16'd7, 16'd13, 16'd15};
`ifdef MAXPOOL_RELU_EN
      vecs[1].res = '{16'h0000, 16'h0000, 16'h0000, 16'h0000};
`else
      vecs[1].res = '{16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF};
`endif
      vecs[2].pix = '{16'h8000, 16'h8000, 16'h7FFF, 16'h8000,
                      16'h8001, 16'h8000, 16'h0000, 16'hFFFF,
                      16'hFFFE, 16'hFFFF, 16'h1234, 16'h1234,
                      16'hFFFD, 16'hFFFE, 16'h1233, 16'h0001};
`ifdef MAXPOOL_RELU_EN
      vecs[2].res = '{16'h0000, 16'h7FFF, 16'h0000, 16'h1234};
`else
      vecs[2].res = '{16'h8001, 16'h7FFF, 16'hFFFF, 16'h1234};
`endif
      vecs[3].res = '{16'd15, 16'd13, 16'd7, 16'd5};
      partial.res = '{16'd0, 16'd0, 16'd0, 16'd0};

      #2;
      checkOutput("resetValid", out_valid, 0);
      checkOutput("resetData", out_data, 0);
      checkOutput("resetLast", out_last, 0);
      checkOutput("resetInReady", in_ready, 1);
      #10 master_rst_n = 1'b1;

      for (int v = 0; v < 4; v++) begin
         applyStimulus(vecs[v], 16, 1'b1, cyc);
         checkOutput("throughputCycles", cyc, 16);
         drainCheck("tableDrain");
      end

      // Back-pressure: first result must hold and inputs must stall until the consumer returns.
      out_ready = 1'b0;
      fork
         applyStimulus(vecs[0], 16, 1'b1, cyc);
         begin
            w = 0;
            while (!out_valid && w < 100) begin
               @(negedge clk);
               w++;
            end
            checkOutput("bpValidSeen", out_valid, 1);
            repeat (4) begin
               @(negedge clk);
               checkOutput("bpHoldData", out_data, 5);
               checkOutput("bpHoldLast", out_last, 0);
               checkOutput("bpInReady", in_ready, 0);
            end
            @(posedge clk);
            #1;
            out_ready = 1'b1;
         end
      join
      drainCheck("bpDrain");

      // Frame abort: a pending partial-frame result is discarded, then a clean frame follows.
      out_ready = 1'b0;
      applyStimulus(partial, 6, 1'b0, cyc);
      frame_clr = 1'b1;
      @(negedge clk);
      checkOutput("clrInReady", in_ready, 0);
      checkOutput("clrPendingValid", out_valid, 1);
      @(posedge clk);
      #1;
      frame_clr = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      checkOutput("clrValidCleared", out_valid, 0);
      applyStimulus(vecs[0], 16, 1'b1, cyc);
      drainCheck("clrDrain");

      // Asynchronous reset between edges mid-frame, then a full frame from scratch.
      out_ready = 1'b0;
      applyStimulus(vecs[0], 6, 1'b0, cyc);
      #2;
      checkOutput("preRstData", out_data, 5);
      checkOutput("preRstValid", out_valid, 1);
      master_rst_n = 1'b0;
      #1;
      checkOutput("asyncRstValid", out_valid, 0);
      checkOutput("asyncRstData", out_data, 0);
      checkOutput("asyncRstLast", out_last, 0);
      @(negedge clk);
      master_rst_n = 1'b1;
      out_ready = 1'b1;
      applyStimulus(vecs[3], 16, 1'b1, cyc);
      checkOutput("postRstThroughput", cyc, 16);
      drainCheck("postRstDrain");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
